// File: rtl/trigger_scheduler_pkg.sv
// trigger_scheduler_pkg
//   Shared instruction-side definitions for the triggered-instruction scheduler:
//   sizing constants, the per-instruction trigger_t layout, the scheduler
//   state encoding, the ptm true/false half layout and the channel-slot
//   "unused" encoding used by the ici/oci lists.
package trigger_scheduler_pkg;

    localparam int TIA_MAX_NUM_INSTRUCTIONS    = 8;
    localparam int TIA_INSTRUCTION_INDEX_WIDTH = $clog2(TIA_MAX_NUM_INSTRUCTIONS);
    localparam int TIA_NUM_PREDICATES          = 8;
    localparam int TIA_NUM_INPUT_CHANNELS      = 4;
    localparam int TIA_NUM_OUTPUT_CHANNELS     = 4;
    localparam int TIA_TAG_WIDTH               = 2;

    // Each instruction names up to this many input / output channels.
    localparam int TIA_NUM_ICI_SLOTS = 2;
    localparam int TIA_NUM_OCI_SLOTS = 2;

    // A channel slot carries one extra bit above the channel index so that a
    // value at or above the channel count marks the slot unused.
    localparam int TIA_CHANNEL_INDEX_WIDTH = 2;
    localparam int TIA_CHANNEL_SLOT_WIDTH  = TIA_CHANNEL_INDEX_WIDTH + 1;
    localparam logic [TIA_CHANNEL_SLOT_WIDTH-1:0] TIA_UNUSED_SLOT = '1;

    typedef logic [TIA_CHANNEL_SLOT_WIDTH-1:0] chan_slot_t;

    // ptm layout: upper half = predicates that must be 1,
    //             lower half = predicates that must be 0.
    localparam int TIA_PTM_WIDTH     = 2 * TIA_NUM_PREDICATES;
    localparam int TIA_PTM_TRUE_LSB  = TIA_NUM_PREDICATES;
    localparam int TIA_PTM_FALSE_LSB = 0;

    typedef struct packed {
        logic                                              vi;
        logic [TIA_PTM_WIDTH-1:0]                          ptm;
        chan_slot_t [TIA_NUM_ICI_SLOTS-1:0]                ici;
        logic [TIA_NUM_ICI_SLOTS-1:0]                      ictb;
        logic [TIA_NUM_ICI_SLOTS-1:0][TIA_TAG_WIDTH-1:0]   ictv;
        chan_slot_t [TIA_NUM_OCI_SLOTS-1:0]                oci;
    } trigger_t;

    // Scheduler states.
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_SEARCH = 2'd0;
    localparam sched_state_t ST_HOLD   = 2'd1;
    localparam sched_state_t ST_WAIT   = 2'd2;
    localparam sched_state_t ST_HALTED = 2'd3;

    function automatic logic [TIA_NUM_PREDICATES-1:0] ptm_true_half(
        input logic [TIA_PTM_WIDTH-1:0] ptm
    );
        return ptm[TIA_PTM_TRUE_LSB +: TIA_NUM_PREDICATES];
    endfunction

    function automatic logic [TIA_NUM_PREDICATES-1:0] ptm_false_half(
        input logic [TIA_PTM_WIDTH-1:0] ptm
    );
        return ptm[TIA_PTM_FALSE_LSB +: TIA_NUM_PREDICATES];
    endfunction

    function automatic logic slot_in_use(input chan_slot_t slot, input int num_channels);
        return (int'(slot) < num_channels);
    endfunction

endpackage

// File: rtl/trigger_resolver.sv
// trigger_resolver
//   Evaluates whether one instruction's trigger is satisfied by the current
//   predicate and channel state. Purely combinational.
//   Ports:
//     trigger_i              - trigger fields of this instruction
//     predicates_i           - current predicate state
//     input_channel_empty_i  - per input channel empty flag
//     input_channel_tags_i   - head tag of each input channel
//     output_channel_full_i  - per output channel full flag
//     triggerable_o          - all trigger conditions hold
module trigger_resolver
    import trigger_scheduler_pkg::*;
(
    input  trigger_t                                                 trigger_i,
    input  logic [TIA_NUM_PREDICATES-1:0]                            predicates_i,
    input  logic [TIA_NUM_INPUT_CHANNELS-1:0]                        input_channel_empty_i,
    input  logic [TIA_NUM_INPUT_CHANNELS-1:0][TIA_TAG_WIDTH-1:0]     input_channel_tags_i,
    input  logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                       output_channel_full_i,
    output logic                                                     triggerable_o
);

    logic [TIA_NUM_PREDICATES-1:0] must_be_true;
    logic [TIA_NUM_PREDICATES-1:0] must_be_false;

    assign must_be_true  = ptm_true_half(trigger_i.ptm);
    assign must_be_false = ptm_false_half(trigger_i.ptm);

    always_comb begin
        triggerable_o = trigger_i.vi;
        if ((predicates_i & must_be_true) != must_be_true) triggerable_o = 1'b0;
        if ((predicates_i & must_be_false) != '0)          triggerable_o = 1'b0;

        for (int s = 0; s < TIA_NUM_ICI_SLOTS; s++) begin
            if (slot_in_use(trigger_i.ici[s], TIA_NUM_INPUT_CHANNELS)) begin
                if (input_channel_empty_i[trigger_i.ici[s][TIA_CHANNEL_INDEX_WIDTH-1:0]])
                    triggerable_o = 1'b0;
                // Tag check only applies to slots that ask for it.
                if (trigger_i.ictb[s] &&
                    input_channel_tags_i[trigger_i.ici[s][TIA_CHANNEL_INDEX_WIDTH-1:0]]
                        != trigger_i.ictv[s])
                    triggerable_o = 1'b0;
            end
        end

        for (int s = 0; s < TIA_NUM_OCI_SLOTS; s++) begin
            if (slot_in_use(trigger_i.oci[s], TIA_NUM_OUTPUT_CHANNELS) &&
                output_channel_full_i[trigger_i.oci[s][TIA_CHANNEL_INDEX_WIDTH-1:0]])
                triggerable_o = 1'b0;
        end
    end

endmodule

// File: rtl/trigger_scheduler.sv
// trigger_scheduler
//   Picks the lowest-indexed triggerable instruction and issues it to the
//   datapath with a valid/ready handshake, allowing only one instruction in
//   flight until it retires. Supports host halt and a freeze enable.
//   Ports:
//     clock, reset                 - clock, synchronous active-high reset
//     enable                       - low freezes all scheduler state
//     halt_req                     - host request to stop issuing
//     triggers                     - trigger fields for every instruction
//     predicates                   - current predicate state
//     input_channel_empty/_tags    - input channel status and head tags
//     output_channel_full          - output channel status
//     datapath_ready               - datapath accepts the presented issue
//     retire                       - oldest issued instruction has completed
//     triggered_instruction_valid  - issue valid (registered)
//     triggered_instruction_index  - issued instruction index (registered)
//     halted                       - scheduler is halted
//     issue_count                  - number of accepted issues, wraps
module trigger_scheduler
    import trigger_scheduler_pkg::*;
(
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic                                                 enable,
    input  logic                                                 halt_req,
    input  trigger_t [TIA_MAX_NUM_INSTRUCTIONS-1:0]              triggers,
    input  logic [TIA_NUM_PREDICATES-1:0]                        predicates,
    input  logic [TIA_NUM_INPUT_CHANNELS-1:0]                    input_channel_empty,
    input  logic [TIA_NUM_INPUT_CHANNELS-1:0][TIA_TAG_WIDTH-1:0] input_channel_tags,
    input  logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                   output_channel_full,
    input  logic                                                 datapath_ready,
    input  logic                                                 retire,
    output logic                                                 triggered_instruction_valid,
    output logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0]               triggered_instruction_index,
    output logic                                                 halted,
    output logic [31:0]                                          issue_count
);

    logic [TIA_MAX_NUM_INSTRUCTIONS-1:0]    triggerable;
    logic                                   any_triggerable;
    logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] winner;

    sched_state_t                           state_q, state_d;
    logic                                   valid_q, valid_d;
    logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] index_q, index_d;
    logic [31:0]                            count_q, count_d;

    for (genvar g = 0; g < TIA_MAX_NUM_INSTRUCTIONS; g++) begin : g_resolver
        trigger_resolver u_resolver (
            .trigger_i             (triggers[g]),
            .predicates_i          (predicates),
            .input_channel_empty_i (input_channel_empty),
            .input_channel_tags_i  (input_channel_tags),
            .output_channel_full_i (output_channel_full),
            .triggerable_o         (triggerable[g])
        );
    end

    // Fixed priority: scan high to low so the lowest set index is left last.
    always_comb begin
        any_triggerable = 1'b0;
        winner          = '0;
        for (int i = TIA_MAX_NUM_INSTRUCTIONS - 1; i >= 0; i--) begin
            if (triggerable[i]) begin
                any_triggerable = 1'b1;
                winner          = TIA_INSTRUCTION_INDEX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        index_d = index_q;
        count_d = count_q;
        case (state_q)
            ST_SEARCH: begin
                // Halt beats a pending trigger so the host can stop cleanly.
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (any_triggerable) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                    index_d = winner;
                end
            end
            ST_HOLD: begin
                // halt_req is deliberately ignored here: the handshake completes first.
                if (datapath_ready) begin
                    state_d = ST_WAIT;
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                end
            end
            ST_WAIT: begin
                // Retire is only looked at once already in WAIT, so a pulse
                // coinciding with the handshake cannot skip this state.
                if (retire) state_d = halt_req ? ST_HALTED : ST_SEARCH;
            end
            ST_HALTED: begin
                if (!halt_req) state_d = ST_SEARCH;
            end
            default: begin
                state_d = ST_SEARCH;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_SEARCH;
            valid_q <= 1'b0;
            index_q <= '0;
            count_q <= '0;
        end else if (enable) begin
            state_q <= state_d;
            valid_q <= valid_d;
            index_q <= index_d;
            count_q <= count_d;
        end
    end

    assign triggered_instruction_valid = valid_q;
    assign triggered_instruction_index = index_q;
    assign halted                      = (state_q == ST_HALTED);
    assign issue_count                 = count_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
module tb_trigger_scheduler;
    import trigger_scheduler_pkg::*;

    localparam int N   = TIA_MAX_NUM_INSTRUCTIONS;
    localparam int IW  = TIA_INSTRUCTION_INDEX_WIDTH;
    localparam int P   = TIA_NUM_PREDICATES;
    localparam int NIC = TIA_NUM_INPUT_CHANNELS;
    localparam int NOC = TIA_NUM_OUTPUT_CHANNELS;
    localparam int TW  = TIA_TAG_WIDTH;

    logic clock = 1'b0;
    logic reset, enable, halt_req, datapath_ready, retire;
    trigger_t [N-1:0]            triggers;
    logic [P-1:0]                predicates;
    logic [NIC-1:0]              input_channel_empty;
    logic [NIC-1:0][TW-1:0]      input_channel_tags;
    logic [NOC-1:0]              output_channel_full;
    logic                        triggered_instruction_valid;
    logic [IW-1:0]               triggered_instruction_index;
    logic                        halted;
    logic [31:0]                 issue_count;

    int n_pass  = 0;
    int n_total = 0;

    trigger_scheduler dut (
        .clock                       (clock),
        .reset                       (reset),
        .enable                      (enable),
        .halt_req                    (halt_req),
        .triggers                    (triggers),
        .predicates                  (predicates),
        .input_channel_empty         (input_channel_empty),
        .input_channel_tags          (input_channel_tags),
        .output_channel_full         (output_channel_full),
        .datapath_ready              (datapath_ready),
        .retire                      (retire),
        .triggered_instruction_valid (triggered_instruction_valid),
        .triggered_instruction_index (triggered_instruction_index),
        .halted                      (halted),
        .issue_count                 (issue_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Instruction with no conditions besides vi=1.
    function automatic trigger_t trig_always();
        trigger_t t;
        t = '0;
        t.vi = 1'b1;
        for (int s = 0; s < TIA_NUM_ICI_SLOTS; s++) t.ici[s] = TIA_UNUSED_SLOT;
        for (int s = 0; s < TIA_NUM_OCI_SLOTS; s++) t.oci[s] = TIA_UNUSED_SLOT;
        return t;
    endfunction

    task automatic clear_inputs();
        enable              = 1'b1;
        halt_req            = 1'b0;
        datapath_ready      = 1'b0;
        retire              = 1'b0;
        triggers            = '0;
        predicates          = '0;
        input_channel_empty = '0;
        input_channel_tags  = '0;
        output_channel_full = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference: trigger rules taken straight from the instruction semantics.
    function automatic bit ref_trig(trigger_t t);
        logic [P-1:0] tru, fal;
        int c;
        if (!t.vi) return 0;
        tru = t.ptm[2*P-1:P];
        fal = t.ptm[P-1:0];
        for (int p = 0; p < P; p++) begin
            if (tru[p] && !predicates[p]) return 0;
            if (fal[p] && predicates[p]) return 0;
        end
        for (int s = 0; s < TIA_NUM_ICI_SLOTS; s++) begin
            if (int'(t.ici[s]) < NIC) begin
                c = int'(t.ici[s]);
                if (input_channel_empty[c]) return 0;
                if (t.ictb[s] && input_channel_tags[c] != t.ictv[s]) return 0;
            end
        end
        for (int s = 0; s < TIA_NUM_OCI_SLOTS; s++) begin
            if (int'(t.oci[s]) < NOC) begin
                c = int'(t.oci[s]);
                if (output_channel_full[c]) return 0;
            end
        end
        return 1;
    endfunction

    function automatic int ref_winner();
        for (int i = 0; i < N; i++) if (ref_trig(triggers[i])) return i;
        return -1;
    endfunction

    task automatic test_reset();
        clear_inputs();
        enable = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", triggered_instruction_valid); else n_pass++;
        n_total++; if (triggered_instruction_index !== '0) $display("FAIL reset_index: got %0d want 0", triggered_instruction_index); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
        n_total++; if (issue_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", issue_count); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        triggers[2] = trig_always();
        triggers[5] = trig_always();
        datapath_ready = 1'b1;
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b1) $display("FAIL prio_valid: got %b want 1", triggered_instruction_valid); else n_pass++;
        n_total++; if (triggered_instruction_index !== IW'(2)) $display("FAIL prio_index: got %0d want 2", triggered_instruction_index); else n_pass++;
        tick();
        n_total++; if (issue_count !== 32'd1) $display("FAIL prio_count: got %0d want 1", issue_count); else n_pass++;
        n_total++; if (triggered_instruction_valid !== 1'b0) $display("FAIL prio_wait_valid: got %b want 0", triggered_instruction_valid); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        triggers[3] = trig_always();
        tick();
        for (int c = 0; c < 4; c++) begin
            n_total++; if (triggered_instruction_valid !== 1'b1 || triggered_instruction_index !== IW'(3))
                $display("FAIL stall_hold c%0d: got v=%b i=%0d want v=1 i=3", c, triggered_instruction_valid, triggered_instruction_index);
            else n_pass++;
            n_total++; if (issue_count !== 32'd0) $display("FAIL stall_count c%0d: got %0d want 0", c, issue_count); else n_pass++;
            if (c < 3) tick();
        end
        datapath_ready = 1'b1;
        tick();
        n_total++; if (issue_count !== 32'd1) $display("FAIL stall_accept_count: got %0d want 1", issue_count); else n_pass++;
        n_total++; if (triggered_instruction_valid !== 1'b0) $display("FAIL stall_accept_valid: got %b want 0", triggered_instruction_valid); else n_pass++;
    endtask

    task automatic test_interlock();
        do_reset();
        triggers[0] = trig_always();
        datapath_ready = 1'b1;
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            n_total++; if (triggered_instruction_valid !== 1'b0 || issue_count !== 32'd1)
                $display("FAIL interlock_wait c%0d: got v=%b n=%0d want v=0 n=1", c, triggered_instruction_valid, issue_count);
            else n_pass++;
        end
        retire = 1'b1;
        tick();
        retire = 1'b0;
        n_total++; if (triggered_instruction_valid !== 1'b0) $display("FAIL interlock_gap: got %b want 0", triggered_instruction_valid); else n_pass++;
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b1 || triggered_instruction_index !== IW'(0))
            $display("FAIL interlock_reissue: got v=%b i=%0d want v=1 i=0", triggered_instruction_valid, triggered_instruction_index);
        else n_pass++;
        tick();
        n_total++; if (issue_count !== 32'd2) $display("FAIL interlock_count: got %0d want 2", issue_count); else n_pass++;
    endtask

    task automatic test_tag_channel();
        trigger_t t;
        do_reset();
        t = trig_always();
        t.ici[0]  = 3'd2;
        t.ictb[0] = 1'b1;
        t.ictv[0] = 2'd2;
        triggers[1] = t;
        input_channel_tags[2] = 2'd1;
        tick();
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b0) $display("FAIL tag_mismatch: got %b want 0", triggered_instruction_valid); else n_pass++;
        input_channel_tags[2] = 2'd2;
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b1 || triggered_instruction_index !== IW'(1))
            $display("FAIL tag_match: got v=%b i=%0d want v=1 i=1", triggered_instruction_valid, triggered_instruction_index);
        else n_pass++;
        datapath_ready = 1'b1;
        tick();
        datapath_ready = 1'b0;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        t.oci[0] = 3'd1;
        triggers[1] = t;
        output_channel_full[1] = 1'b1;
        tick();
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b0) $display("FAIL oci_full: got %b want 0", triggered_instruction_valid); else n_pass++;
        output_channel_full[1] = 1'b0;
        input_channel_empty[2] = 1'b1;
        tick();
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b0) $display("FAIL ici_empty: got %b want 0", triggered_instruction_valid); else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        triggers[4] = trig_always();
        tick();
        halt_req = 1'b1;
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b1 || halted !== 1'b0)
            $display("FAIL halt_in_hold: got v=%b h=%b want v=1 h=0", triggered_instruction_valid, halted);
        else n_pass++;
        datapath_ready = 1'b1;
        tick();
        datapath_ready = 1'b0;
        n_total++; if (issue_count !== 32'd1 || halted !== 1'b0)
            $display("FAIL halt_handshake: got n=%0d h=%b want n=1 h=0", issue_count, halted);
        else n_pass++;
        tick();
        n_total++; if (halted !== 1'b0) $display("FAIL halt_before_retire: got %b want 0", halted); else n_pass++;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        n_total++; if (halted !== 1'b1) $display("FAIL halt_after_retire: got %b want 1", halted); else n_pass++;
        tick();
        n_total++; if (halted !== 1'b1 || triggered_instruction_valid !== 1'b0)
            $display("FAIL halt_stays: got h=%b v=%b want h=1 v=0", halted, triggered_instruction_valid);
        else n_pass++;
        halt_req = 1'b0;
        tick();
        n_total++; if (halted !== 1'b0) $display("FAIL halt_release: got %b want 0", halted); else n_pass++;
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b1) $display("FAIL halt_resume_issue: got %b want 1", triggered_instruction_valid); else n_pass++;
        // Halt from SEARCH wins over a pending trigger.
        do_reset();
        triggers[4] = trig_always();
        halt_req = 1'b1;
        tick();
        n_total++; if (halted !== 1'b1 || triggered_instruction_valid !== 1'b0)
            $display("FAIL halt_search: got h=%b v=%b want h=1 v=0", halted, triggered_instruction_valid);
        else n_pass++;
        halt_req = 1'b0;
    endtask

    task automatic test_enable();
        do_reset();
        triggers[6] = trig_always();
        tick();
        enable = 1'b0;
        datapath_ready = 1'b1;
        tick();
        tick();
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b1 || triggered_instruction_index !== IW'(6) || issue_count !== 32'd0)
            $display("FAIL enable_freeze: got v=%b i=%0d n=%0d want v=1 i=6 n=0", triggered_instruction_valid, triggered_instruction_index, issue_count);
        else n_pass++;
        enable = 1'b1;
        tick();
        n_total++; if (issue_count !== 32'd1 || triggered_instruction_valid !== 1'b0)
            $display("FAIL enable_resume: got n=%0d v=%b want n=1 v=0", issue_count, triggered_instruction_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        triggers[7] = trig_always();
        datapath_ready = 1'b1;
        tick();
        tick();
        triggers = '0;
        datapath_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++; if (triggered_instruction_valid !== 1'b0 || issue_count !== 32'd0 || halted !== 1'b0)
            $display("FAIL rstwait_clear: got v=%b n=%0d h=%b want v=0 n=0 h=0", triggered_instruction_valid, issue_count, halted);
        else n_pass++;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        n_total++; if (triggered_instruction_valid !== 1'b0 || issue_count !== 32'd0)
            $display("FAIL rstwait_late_retire: got v=%b n=%0d want v=0 n=0", triggered_instruction_valid, issue_count);
        else n_pass++;
        triggers[7] = trig_always();
        tick();
        n_total++; if (triggered_instruction_valid !== 1'b1 || triggered_instruction_index !== IW'(7))
            $display("FAIL rstwait_search: got v=%b i=%0d want v=1 i=7", triggered_instruction_valid, triggered_instruction_index);
        else n_pass++;
    endtask

    task automatic test_random();
        bit          m_valid, m_inflight, m_halted;
        int          m_idx, w;
        int unsigned m_count;
        trigger_t    t;
        do_reset();
        m_valid = 0; m_inflight = 0; m_halted = 0; m_idx = 0; m_count = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                t = '0;
                t.vi  = ($urandom_range(3) != 0);
                t.ptm = TIA_PTM_WIDTH'($urandom & $urandom & $urandom);
                for (int s = 0; s < TIA_NUM_ICI_SLOTS; s++) begin
                    t.ici[s]  = chan_slot_t'($urandom_range(7));
                    t.ictb[s] = ($urandom_range(3) == 0);
                    t.ictv[s] = TW'($urandom);
                end
                for (int s = 0; s < TIA_NUM_OCI_SLOTS; s++) t.oci[s] = chan_slot_t'($urandom_range(7));
                triggers[i] = t;
            end
            predicates          = P'($urandom);
            input_channel_empty = NIC'($urandom & $urandom);
            input_channel_tags  = (NIC*TW)'($urandom);
            output_channel_full = NOC'($urandom & $urandom);
            enable         = ($urandom_range(7) != 0);
            halt_req       = ($urandom_range(9) == 0);
            datapath_ready = $urandom_range(1) == 1;
            retire         = ($urandom_range(2) == 0);

            if (enable) begin
                if (m_halted) begin
                    if (!halt_req) m_halted = 0;
                end else if (m_valid) begin
                    if (datapath_ready) begin m_valid = 0; m_inflight = 1; m_count++; end
                end else if (m_inflight) begin
                    if (retire) begin m_inflight = 0; m_halted = halt_req; end
                end else if (halt_req) begin
                    m_halted = 1;
                end else begin
                    w = ref_winner();
                    if (w >= 0) begin m_valid = 1; m_idx = w; end
                end
            end
            tick();
            n_total++; if (triggered_instruction_valid !== m_valid) $display("FAIL rnd_valid c%0d: got %b want %b", cyc, triggered_instruction_valid, m_valid); else n_pass++;
            n_total++; if (triggered_instruction_index !== IW'(m_idx)) $display("FAIL rnd_index c%0d: got %0d want %0d", cyc, triggered_instruction_index, m_idx); else n_pass++;
            n_total++; if (halted !== m_halted) $display("FAIL rnd_halted c%0d: got %b want %b", cyc, halted, m_halted); else n_pass++;
            n_total++; if (issue_count !== m_count) $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, issue_count, m_count); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_stall();
        test_interlock();
        test_tag_channel();
        test_halt();
        test_enable();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trigger_scheduler.md
TRIGGER_SCHEDULER -- requirements
Module: trigger_scheduler

Interface
REQ-001 Parameters: none; all sizes come from the shared package constants (TIA_MAX_NUM_INSTRUCTIONS, TIA_INSTRUCTION_INDEX_WIDTH, TIA_NUM_PREDICATES, TIA_NUM_INPUT_CHANNELS, TIA_NUM_OUTPUT_CHANNELS, TIA_TAG_WIDTH).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Ports: clock, reset.
REQ-003 clock  in  1  positive-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  active high; low freezes the scheduler.
REQ-006 halt_req  in  1  host request to stop issuing.
REQ-007 triggers  in  trigger_t[TIA_MAX_NUM_INSTRUCTIONS]  per-instruction trigger fields (vi, ptm, ici, ictb, ictv, oci) from instruction memory.
REQ-008 predicates  in  TIA_NUM_PREDICATES  current predicate state.
REQ-009 input_channel_empty  in  TIA_NUM_INPUT_CHANNELS  per-channel empty flag.
REQ-010 input_channel_tags  in  TIA_TAG_WIDTH x TIA_NUM_INPUT_CHANNELS  head tag of each channel.
REQ-011 output_channel_full  in  TIA_NUM_OUTPUT_CHANNELS  per-channel full flag.
REQ-012 datapath_ready  in  1  downstream accepts an issued instruction this cycle.
REQ-013 retire  in  1  one-cycle pulse: the oldest issued instruction has updated predicates and channels.
REQ-014 triggered_instruction_valid  out  1  issue valid.
REQ-015 triggered_instruction_index  out  TIA_INSTRUCTION_INDEX_WIDTH  issued instruction index.
REQ-016 halted  out  1  scheduler is in HALTED.
REQ-017 issue_count  out  32  count of accepted issues.

Function
REQ-018 Instruction i SHALL be triggerable when all of the following hold:
- vi=1.
- Every predicate selected by the ptm true half is 1, and every predicate selected by the false half is 0.
- Every channel listed in ici is non-empty.
- Where ictb is set, the head tag of that channel equals ictv.
- Every channel listed in oci is not full.
REQ-019 Selection SHALL be a fixed priority: the lowest triggerable index wins. This logic is purely combinational.
REQ-020 States SHALL be SEARCH, HOLD, WAIT and HALTED; the reset state is SEARCH.
REQ-021 SEARCH: if any instruction is triggerable and halt_req=0, register the winning index and assert valid in the next cycle, entering HOLD. Otherwise stay in SEARCH with valid=0. Search-to-valid latency is one cycle.
REQ-022 HOLD: valid=1 and the index SHALL remain stable until datapath_ready=1.
- On datapath_ready=1, go to WAIT and increment issue_count.
- Triggers are not re-evaluated while in HOLD.
REQ-023 WAIT: valid=0 until retire=1, then go to SEARCH (or to HALTED if halt_req=1). At most one instruction is in flight, which prevents stale-predicate hazards.
REQ-024 A retire pulse that arrives outside WAIT SHALL be ignored.
REQ-025 If retire=1 arrives in the same cycle the scheduler enters WAIT, it SHALL be honoured on the next cycle only; the scheduler does not skip WAIT.
REQ-026 halt_req=1 SHALL take effect as follows:
- In SEARCH: go to HALTED next cycle.
- In HOLD: complete the handshake first.
- In WAIT: take effect after retire.
REQ-027 HALTED SHALL keep valid=0 and halted=1, and return to SEARCH when halt_req=0.
REQ-028 enable=0 SHALL freeze the state, index, valid and issue_count. A HOLD issue stays presented, but the handshake is not accepted while enable=0.
REQ-029 issue_count SHALL wrap modulo 2^32.
REQ-030 Output registers SHALL be updated only on the clock edge; no output depends combinationally on datapath_ready.

Reset
REQ-031 While reset=1, the scheduler SHALL go to SEARCH with valid=0, index=0, halted=0 and issue_count=0, regardless of enable.
REQ-032 A reset in HOLD or WAIT SHALL drop the in-flight issue without a handshake; a subsequent retire pulse is then ignored per REQ-024.

Structure
REQ-033 The shared instruction package SHALL hold:
- trigger_t.
- The scheduler state enum.
- The ptm true/false half layout.
- The ici/oci unused-slot encoding.
REQ-034 Per-instruction trigger evaluation SHALL be a sub-module named trigger_resolver, instantiated once per instruction and feeding a priority encoder in this module.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Priority: instructions 2 and 5 both triggerable, datapath_ready=1 -> index 2 is issued with valid one cycle later and issue_count=1.
- Stall: issue index 3 with datapath_ready=0 for 4 cycles -> valid and index=3 held for 4 cycles, issue_count increments only on the ready cycle.
- Interlock: instruction 0 remains triggerable, no retire for 6 cycles -> exactly one issue; after retire, the second issue appears two cycles later.
- Tag and channel: ictb=1, ictv=2, head tag=1 -> no issue; head tag changes to 2 -> issue. Setting the oci channel full -> no issue.
- Halt: halt_req asserted during HOLD -> the handshake completes, then HALTED after retire and halted=1; halt_req deasserted -> back to SEARCH.
- Reset mid-WAIT: reset asserted -> valid=0, issue_count=0, state SEARCH; a late retire pulse has no effect.
